// File: rtl/mult_pkg.sv
// Shared types and constants for the 8x8 signed shift-add multiplier controller.
// MULT_SINGLE_CYCLE_EN selects the merged ADDSHIFT iteration state.
package mult_pkg;

  localparam int         WIDTH     = 8;
  localparam logic [2:0] LAST_ITER = 3'd7;

`ifdef MULT_SINGLE_CYCLE_EN
  typedef enum logic [1:0] {IDLE, ADDSHIFT, HALT} state_t;
`else
  typedef enum logic [1:0] {IDLE, ADD, SHIFT, HALT} state_t;
`endif

endpackage

// File: rtl/mult_ctrl_if.sv
// Link between mult_ctrl and the upstream 8-bit add/sub stage.
// The controller is the master: it drives the operands and function select and consumes the sum.
interface mult_ctrl_if;
  import mult_pkg::*;

  logic signed [WIDTH-1:0] add_a;
  logic signed [WIDTH-1:0] add_b;
  logic                    add_fn;
  logic signed [WIDTH-1:0] add_s;
  logic                    add_x;

  modport master (output add_a, add_b, add_fn, input add_s, add_x);
  modport slave  (input add_a, add_b, add_fn, output add_s, add_x);
endinterface

// File: rtl/mult_ctrl_shift_reg_17.sv
// 17-bit {X, A, B} register: parallel load of X/A, load of B, and an arithmetic right shift
// applied after any load in the same edge, so a merged add+shift iteration needs no extra state.
module shift_reg_17
  import mult_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    load_ax,
  input  logic                    x_in,
  input  logic signed [WIDTH-1:0] a_in,
  input  logic                    load_b,
  input  logic        [WIDTH-1:0] b_in,
  input  logic                    shift_en,
  output logic                    x_out,
  output logic signed [WIDTH-1:0] a_out,
  output logic        [WIDTH-1:0] b_out
);

  logic [2*WIDTH:0] xab_q;
  logic [2*WIDTH:0] xab_d;
  logic [2*WIDTH:0] xab_ld;

  always_comb begin
    xab_ld = xab_q;
    if (load_ax) xab_ld[2*WIDTH:WIDTH] = {x_in, a_in};
    if (load_b)  xab_ld[WIDTH-1:0]     = b_in;
    xab_d = xab_ld;
    // X is duplicated into A[7] so {X,A} stays a sign-extended partial product
    if (shift_en) xab_d = {xab_ld[2*WIDTH], xab_ld[2*WIDTH:1]};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) xab_q <= '0;
    else        xab_q <= xab_d;
  end

  assign x_out = xab_q[2*WIDTH];
  assign a_out = xab_q[2*WIDTH-1:WIDTH];
  assign b_out = xab_q[WIDTH-1:0];

endmodule

// File: rtl/mult_ctrl.sv
// Sequential 8x8 signed shift-add multiplier controller; product ends in {A,B}, sign in X.
// Define MULT_SINGLE_CYCLE_EN to fold add and shift into one ADDSHIFT state (8-cycle latency).
module mult_ctrl
  import mult_pkg::*;
(
  input  logic              Clk,
  input  logic              Reset_n,
  input  logic [WIDTH-1:0]  SW,
  input  logic              Run,
  input  logic              ClearA_LoadB,
  mult_ctrl_if.master       addsub,
  output logic [WIDTH-1:0]  Aval,
  output logic [WIDTH-1:0]  Bval,
  output logic              Xval,
  output logic              Done
);

  state_t                  state_q;
  logic [2:0]              iter_q;
  logic                    done_q;

  logic                    load_ax;
  logic                    load_b;
  logic                    shift_en;
  logic                    x_in;
  logic signed [WIDTH-1:0] a_in;
  logic                    fn;
  logic                    x_val;
  logic signed [WIDTH-1:0] a_val;
  logic        [WIDTH-1:0] b_val;

  always_comb begin
    load_ax  = 1'b0;
    load_b   = 1'b0;
    shift_en = 1'b0;
    fn       = 1'b0;
    a_in     = addsub.add_s;
    x_in     = addsub.add_x;
    unique case (state_q)
      IDLE: begin
        a_in = '0;
        x_in = 1'b0;
        // load wins over start; both paths clear A and X
        if (ClearA_LoadB) begin
          load_ax = 1'b1;
          load_b  = 1'b1;
        end else if (Run) begin
          load_ax = 1'b1;
        end
      end
`ifdef MULT_SINGLE_CYCLE_EN
      ADDSHIFT: begin
        load_ax  = b_val[0];
        shift_en = 1'b1;
        fn       = (iter_q == LAST_ITER);
      end
`else
      ADD: begin
        load_ax = b_val[0];
        fn      = (iter_q == LAST_ITER);
      end
      SHIFT: shift_en = 1'b1;
`endif
      default: ;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q <= IDLE;
      iter_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (!ClearA_LoadB && Run) begin
            iter_q  <= '0;
`ifdef MULT_SINGLE_CYCLE_EN
            state_q <= ADDSHIFT;
`else
            state_q <= ADD;
`endif
          end
        end
`ifdef MULT_SINGLE_CYCLE_EN
        ADDSHIFT: begin
`else
        ADD: state_q <= SHIFT;
        SHIFT: begin
`endif
          iter_q <= iter_q + 3'd1;
          if (iter_q == LAST_ITER) begin
            state_q <= HALT;
            done_q  <= 1'b1;
          end else begin
`ifdef MULT_SINGLE_CYCLE_EN
            state_q <= ADDSHIFT;
`else
            state_q <= ADD;
`endif
          end
        end
        HALT: begin
          if (!Run) begin
            state_q <= IDLE;
            done_q  <= 1'b0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  shift_reg_17 u_xab (
    .clk      (Clk),
    .rst_n    (Reset_n),
    .load_ax  (load_ax),
    .x_in     (x_in),
    .a_in     (a_in),
    .load_b   (load_b),
    .b_in     (SW),
    .shift_en (shift_en),
    .x_out    (x_val),
    .a_out    (a_val),
    .b_out    (b_val)
  );

  assign addsub.add_a  = a_val;
  assign addsub.add_b  = SW;
  assign addsub.add_fn = fn;

  assign Aval = a_val;
  assign Bval = b_val;
  assign Xval = x_val;
  assign Done = done_q;

endmodule

// File: tb/tb_mult_ctrl.sv
// Directed bench for mult_ctrl: models the add/sub stage and predicts outputs from
// transaction-level rules (signed product, fixed latency, Run/ClearA_LoadB semantics).
module tb_mult_ctrl;
  import mult_pkg::*;

`ifdef MULT_SINGLE_CYCLE_EN
  localparam int LAT = 8;
`else
  localparam int LAT = 16;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] sw = 8'h00;
  logic       run = 1'b0;
  logic       clr = 1'b0;
  logic [7:0] aval, bval;
  logic       xval, done;

  int vectors = 0;
  int errors  = 0;

  mult_ctrl_if ifc ();

  mult_ctrl dut (
    .Clk          (clk),
    .Reset_n      (rst_n),
    .SW           (sw),
    .Run          (run),
    .ClearA_LoadB (clr),
    .addsub       (ifc.master),
    .Aval         (aval),
    .Bval         (bval),
    .Xval         (xval),
    .Done         (done)
  );

  always #5 clk = ~clk;

  // Upstream 8-bit add/sub stage with its 9th sign-extension bit
  logic [8:0] sum9;
  always_comb begin
    sum9 = ifc.add_fn ? ({ifc.add_a[7], ifc.add_a} - {ifc.add_b[7], ifc.add_b})
                      : ({ifc.add_a[7], ifc.add_a} + {ifc.add_b[7], ifc.add_b});
  end
  assign ifc.add_s = sum9[7:0];
  assign ifc.add_x = sum9[8];

  // Transaction model: 0 = idle, 1 = multiplying, 2 = product held
  int                 m_phase = 0;
  int                 m_cnt   = 0;
  logic [7:0]         m_a = 8'h00;
  logic [7:0]         m_b = 8'h00;
  logic               m_x = 1'b0;
  logic signed [15:0] m_prod = 16'sd0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_phase = 0; m_cnt = 0; m_a = 8'h00; m_b = 8'h00; m_x = 1'b0;
    end else begin
      case (m_phase)
        0: begin
          if (clr) begin
            m_a = 8'h00; m_x = 1'b0; m_b = sw;
          end else if (run) begin
            m_prod  = $signed(sw) * $signed(m_b);
            m_a     = 8'h00; m_x = 1'b0; m_cnt = 0; m_phase = 1;
          end
        end
        1: begin
          m_cnt++;
          if (m_cnt == LAT) begin
            {m_a, m_b} = m_prod;
            m_x        = m_prod[15];
            m_phase    = 2;
          end
        end
        default: if (!run) m_phase = 0;
      endcase
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    chk("done", {31'd0, done}, {31'd0, m_phase == 2});
    chk("add_b", {24'd0, ifc.add_b}, {24'd0, sw});
    if (m_phase != 1) begin
      chk("A", {24'd0, aval}, {24'd0, m_a});
      chk("B", {24'd0, bval}, {24'd0, m_b});
      chk("X", {31'd0, xval}, {31'd0, m_x});
      chk("add_a", {24'd0, ifc.add_a}, {24'd0, m_a});
      chk("add_fn", {31'd0, ifc.add_fn}, 32'd0);
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic load_b(input logic [7:0] v);
    sw  = v;
    clr = 1'b1;
    step();
    clr = 1'b0;
  endtask

  task automatic do_mult(input logic [7:0] s);
    int cyc;
    sw  = s;
    run = 1'b1;
    cyc = 0;
    do begin
      @(posedge clk);
      cyc++;
      @(negedge clk);
      if (cyc == 1) chk("start_clears_A", {24'd0, aval}, 32'd0);
    end while (!done && cyc < 200);
    #1;
    chk("latency", cyc - 1, LAT);
  endtask

  task automatic release_run();
    run = 1'b0;
    step();
    step();
  endtask

  typedef struct { logic [7:0] b; logic [7:0] s; logic [15:0] p; } vec_t;
  vec_t tbl [3];

  initial begin
    tbl[0] = '{8'h7F, 8'h7F, 16'h3F01};
    tbl[1] = '{8'h80, 8'h7F, 16'hC080};
    tbl[2] = '{8'hF6, 8'h0C, 16'hFF88};

    repeat (2) step();
    chk("rst_A", {24'd0, aval}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    rst_n = 1'b1;
    step();

    // 7 x -3
    load_b(8'h07);
    do_mult(8'hFD);
    chk("p1", {16'd0, aval, bval}, 32'h0000FFEB);
    chk("p1_x", {31'd0, xval}, 32'd1);
    chk("p1_model", {16'd0, m_a, m_b}, 32'h0000FFEB);
    repeat (40) step();
    chk("hold_done", {31'd0, done}, 32'd1);
    chk("hold_p", {16'd0, aval, bval}, 32'h0000FFEB);
    release_run();

    // -128 x -128 exercises the final subtract of a negative multiplicand
    load_b(8'h80);
    do_mult(8'h80);
    chk("p2", {16'd0, aval, bval}, 32'h00004000);
    chk("p2_x", {31'd0, xval}, 32'd0);
    release_run();

    // -1 x 1, then chained with the retained low byte
    load_b(8'hFF);
    do_mult(8'h01);
    chk("p3", {16'd0, aval, bval}, 32'h0000FFFF);
    chk("p3_x", {31'd0, xval}, 32'd1);
    release_run();
    do_mult(8'h01);
    chk("p3_chain", {16'd0, aval, bval}, 32'h0000FFFF);
    release_run();

    // load and start together: load wins, start follows
    sw  = 8'h05;
    clr = 1'b1;
    run = 1'b1;
    step();
    chk("ld_run_B", {24'd0, bval}, 32'h05);
    chk("ld_run_nodone", {31'd0, done}, 32'd0);
    clr = 1'b0;
    do_mult(8'h00);
    chk("p4", {16'd0, aval, bval}, 32'h00000000);
    release_run();

    // reset during the fourth shift iteration
    load_b(8'h07);
    sw  = 8'h03;
    run = 1'b1;
`ifdef MULT_SINGLE_CYCLE_EN
    repeat (4) step();
`else
    repeat (8) step();
`endif
    rst_n = 1'b0;
    #1;
    chk("abort_A", {24'd0, aval}, 32'd0);
    chk("abort_B", {24'd0, bval}, 32'd0);
    chk("abort_X", {31'd0, xval}, 32'd0);
    chk("abort_fn", {31'd0, ifc.add_fn}, 32'd0);
    step();
    rst_n = 1'b1;
    do_mult(8'h03);
    chk("p5", {16'd0, aval, bval}, 32'h00000000);
    release_run();

    foreach (tbl[i]) begin
      load_b(tbl[i].b);
      do_mult(tbl[i].s);
      chk("tbl_p", {16'd0, aval, bval}, {16'd0, tbl[i].p});
      chk("tbl_x", {31'd0, xval}, {31'd0, tbl[i].p[15]});
      release_run();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/mult_ctrl.md
# mult_ctrl

Sequential 8x8 signed shift-add multiplier controller and register file that sits directly downstream of the 8-bit add/sub stage. It owns the accumulator/multiplier shift register {X, A, B}, drives the add/sub stage's operands and function select, and consumes its 8-bit sum and sign-extension bit. One multiply takes 8 iterations; the 16-bit product is left in {A, B} with X holding its sign.

## Interface
- No parameters; the datapath is fixed at 8 bits.
- Clk  in  1  single clock, rising edge
- Reset_n  in  1  asynchronous, active-low reset
- SW  in  8  multiplicand S (held stable during a multiply); also the load value for B
- Run  in  1  level; starts a multiply from IDLE
- ClearA_LoadB  in  1  level; in IDLE, A<=0, X<=0, B<=SW
- add_s  in  8  sum from add/sub stage
- add_x  in  1  9th (sign-extension) bit from add/sub stage
- add_a  out  8  operand A to add/sub stage (= A register)
- add_b  out  8  operand B to add/sub stage (= SW)
- add_fn  out  1  0 = add, 1 = subtract
- Aval, Bval  out  8  A and B registers
- Xval  out  1  X register
- Done  out  1  product valid

## Operation
- States: IDLE, ADD, SHIFT, HALT.
- IDLE: ClearA_LoadB=1 -> A<=0, X<=0, B<=SW; it wins over Run in the same cycle, and the start happens on the next cycle if Run is still 1. Run=1 with no load -> A<=0, X<=0, iter<=0, go to ADD. B is retained, so chained multiplies reuse the prior low byte.
- ADD: if B[0]=1 then A<=add_s, X<=add_x; otherwise A and X are unchanged. add_fn=1 only when iter=7, so the sign-bit weight is subtracted; otherwise 0. Next state is SHIFT.
- SHIFT: {X,A,B} <= {X,X,A,B[7:1]}, an arithmetic right shift with X duplicated. iter<=iter+1. Go to HALT if iter=7, else to ADD.
- HALT: Done=1. Registers hold. When Run=0, go to IDLE. ClearA_LoadB is ignored here.
- Result: {A,B} = signed(SW) x signed(B_initial), two's-complement 16 bits. X = A[7].
- add_a, add_b and add_fn are combinational from the registers and state. add_fn=0 outside ADD.
- iter is a 3-bit counter and wraps only via the reset to 0 at start.

## Timing
- On reset: A=0, B=0, X=0, iter=0, Done=0, state=IDLE, add_fn=0. Reset mid-multiply aborts immediately and returns all of these values.
- Run is sampled high in IDLE at edge 0. Then ADD_k is the cycle after edge 2k and SHIFT_k is the cycle after edge 2k+1. Done=1 from edge 16 onward: 16 cycles of latency.
- Done stays 1 until the edge after Run=0 is sampled. Run held high never retriggers a multiply.
- The add/sub result is used in the same cycle, with a zero-cycle combinational path add_a/add_b -> add_s.
- SW changing during ADD/SHIFT corrupts the product; this is illegal stimulus and is not checked.

## Configuration
- MULT_SINGLE_CYCLE_EN defined: ADD and SHIFT merge into one state, ADDSHIFT. Each cycle it computes the conditional add and shifts the result {add_x|X, add_s|A, B} in the same edge. Done=1 from edge 8. The SHIFT state is not synthesised.
- MULT_SINGLE_CYCLE_EN undefined: two-state iteration as above, 16-cycle latency. Results are identical in both modes.

## Structure
- Package mult_pkg holds:
  - the state enum typedef (IDLE, ADD, SHIFT, HALT; ADDSHIFT under the macro)
  - localparam WIDTH=8
  - localparam LAST_ITER=3'd7
- One sub-module, shift_reg_17: a 17-bit {X,A,B} register with async active-low clear, parallel load of A/X, load of B, and an arithmetic-right-shift enable. The FSM, iter counter and operand muxing stay in mult_ctrl.

## Test plan
- Reset, then ClearA_LoadB with SW=0x07, then Run with SW=0xFD -> Done at edge 16, {A,B}=0xFFEB (-21), X=1.
- B=0x80, SW=0x80 -> {A,B}=0x4000, X=0. This checks the iter-7 subtract of a negative multiplicand.
- B=0xFF, SW=0x01 -> 0xFFFF, X=1. Then release Run and re-run with SW=0x01 without loading: B starts at 0xFF, product 0xFFFF again, and A is cleared at start.
- ClearA_LoadB and Run both high in IDLE with SW=0x05 -> B=0x05 and no start that cycle. The start follows on the next cycle. SW=0x00 -> product 0x0000.
- Reset_n pulsed low during SHIFT_3 -> all outputs 0, state IDLE. With Run held high after reset, a fresh multiply starts and completes correctly.
- Hold Run high 40 cycles after Done -> Done stays 1 and the product is unchanged. Repeat with MULT_SINGLE_CYCLE_EN: Done at edge 8, same products.
